waveform_bank_stream: RTL and testbench

Multi-slot waveform store-and-playback engine: the successor of the single-buffer waveform streamer. The block captures up to NUM_SLOTS waveforms from an AXI-Stream input into an internal block RAM and replays any stored slot on an AXI-Stream output, with a programmable repeat count. It sits between the waveform-parameter/control logic and the DAC-side transmit stream. It replaces the external DataMover/BRAM pair with an inferred dual-port RAM.

---
 rtl/waveform_bank_pkg.sv | 17 +
 rtl/wf_bank_ram.sv | 30 +++
 rtl/waveform_bank_stream.sv | 254 +++++++++++++++++++++++++
 tb/tb_waveform_bank_stream.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/waveform_bank_pkg.sv
// rtl/waveform_bank_pkg.sv - shared types and helpers for the waveform bank streamer
package waveform_bank_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_WRITE = 2'd1,
        STATE_PLAY  = 2'd2,
        STATE_DRAIN = 2'd3
    } state_e;

    localparam int REP_W = 16;

    function automatic logic [31:0] slot_base(input logic [31:0] slot, input int unsigned slot_aw);
        return slot << slot_aw;
    endfunction

endpackage

// File: rtl/wf_bank_ram.sv
// rtl/wf_bank_ram.sv - simple dual-port waveform RAM with registered read
module wf_bank_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // No reset here so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/waveform_bank_stream.sv
// rtl/waveform_bank_stream.sv - multi-slot waveform capture and repeat playback engine
module waveform_bank_stream
    import waveform_bank_pkg::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int SLOT_AW           = 10,
    parameter int NUM_SLOTS         = 4,
    parameter bit WRITE_BEFORE_READ = 1'b1
) (
    input  logic                         clk_in1,
    input  logic                         areset,
    input  logic                         wf_cmd_valid,
    output logic                         wf_cmd_ready,
    input  logic                         wf_cmd_write,
    input  logic [$clog2(NUM_SLOTS)-1:0] wf_cmd_slot,
    input  logic [SLOT_AW:0]             wf_cmd_len,
    input  logic [REP_W-1:0]             wf_cmd_repeat,
    input  logic [DATA_WIDTH-1:0]        wfin_axis_tdata,
    input  logic                         wfin_axis_tvalid,
    input  logic                         wfin_axis_tlast,
    output logic                         wfin_axis_tready,
    output logic [DATA_WIDTH-1:0]        wfout_axis_tdata,
    output logic                         wfout_axis_tvalid,
    output logic                         wfout_axis_tlast,
    output logic [DATA_WIDTH/8-1:0]      wfout_axis_tkeep,
    input  logic                         wfout_axis_tready,
    output logic                         wf_done,
    output logic                         wf_err,
    output logic                         wf_busy
);

    localparam int SW = $clog2(NUM_SLOTS);
    localparam int CW = SLOT_AW + 1;
    localparam int AW = SLOT_AW + SW;
    localparam logic [CW-1:0] FULL_LEN = {1'b1, {SLOT_AW{1'b0}}};

    state_e                          state_q, state_d;
    logic [SW-1:0]                   slot_q, slot_d;
    logic [CW-1:0]                   len_q, len_d;
    logic [REP_W-1:0]                reps_q, reps_d;
    logic [CW-1:0]                   wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]                   rd_addr_q, rd_addr_d;
    logic [REP_W-1:0]                rep_cnt_q, rep_cnt_d;
    logic [NUM_SLOTS-1:0]            written_q, written_d;
    logic [NUM_SLOTS-1:0][CW-1:0]    slot_len_q, slot_len_d;
    logic                            done_q, done_d;
    logic                            err_q, err_d;
    logic                            rd_pend_q, rd_pend_d;
    logic                            rd_last_q, rd_last_d;
    logic [1:0][DATA_WIDTH-1:0]      fifo_data_q, fifo_data_d;
    logic [1:0]                      fifo_last_q, fifo_last_d;
    logic [1:0]                      fifo_cnt_q, fifo_cnt_d;
    logic [1:0]                      fill;

    logic                            accept;
    logic                            len_bad;
    logic                            start_play;
    logic [CW-1:0]                   sel_len;
    logic [CW-1:0]                   play_len;
    logic [REP_W-1:0]                rep_total;
    logic                            pop;
    logic [2:0]                      occ;
    logic                            issue;
    logic [SW-1:0]                   issue_slot;
    logic [CW-1:0]                   issue_addr;
    logic [CW-1:0]                   issue_len;
    logic [REP_W-1:0]                issue_rep;
    logic [REP_W-1:0]                issue_total;
    logic                            issue_wrap;
    logic                            issue_last;
    logic                            wr_last;

    logic                            ram_we;
    logic [AW-1:0]                   ram_waddr;
    logic [AW-1:0]                   ram_raddr;
    logic [DATA_WIDTH-1:0]           ram_rdata;

    assign wf_cmd_ready      = (state_q == STATE_IDLE) && !done_q && !err_q;
    assign wf_busy           = (state_q != STATE_IDLE);
    assign wf_done           = done_q;
    assign wf_err            = err_q;
    assign wfin_axis_tready  = (state_q == STATE_WRITE);
    assign wfout_axis_tvalid = (fifo_cnt_q != 2'd0);
    assign wfout_axis_tdata  = fifo_data_q[0];
    assign wfout_axis_tlast  = wfout_axis_tvalid && fifo_last_q[0];
    assign wfout_axis_tkeep  = '1;

    assign accept     = wf_cmd_valid && wf_cmd_ready;
    assign len_bad    = (wf_cmd_len == '0) || (wf_cmd_len > FULL_LEN);
    assign start_play = accept && !wf_cmd_write
                        && !(WRITE_BEFORE_READ && !written_q[wf_cmd_slot]);
    assign sel_len    = slot_len_q[wf_cmd_slot];
    // An unwritten slot (only playable when reads-before-writes are allowed) plays its full span.
    assign play_len   = (sel_len == '0) ? FULL_LEN : sel_len;
    assign rep_total  = (wf_cmd_repeat == '0) ? REP_W'(1) : wf_cmd_repeat;

    assign pop = wfout_axis_tvalid && wfout_axis_tready;
    assign occ = {1'b0, fifo_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};

    // The first read goes out in the acceptance cycle so data appears two cycles later.
    assign issue_slot  = start_play ? wf_cmd_slot : slot_q;
    assign issue_addr  = start_play ? '0 : rd_addr_q;
    assign issue_len   = start_play ? play_len : len_q;
    assign issue_rep   = start_play ? '0 : rep_cnt_q;
    assign issue_total = start_play ? rep_total : reps_q;
    assign issue       = start_play || ((state_q == STATE_PLAY) && (occ < 3'd2));
    assign issue_wrap  = (issue_addr == issue_len - CW'(1));
    assign issue_last  = issue_wrap && (issue_rep == issue_total - REP_W'(1));

    assign wr_last   = (wr_cnt_q + CW'(1) == len_q) || wfin_axis_tlast;
    assign ram_we    = (state_q == STATE_WRITE) && wfin_axis_tvalid;
    assign ram_waddr = AW'(slot_base(32'(slot_q), SLOT_AW) + 32'(wr_cnt_q[SLOT_AW-1:0]));
    assign ram_raddr = AW'(slot_base(32'(issue_slot), SLOT_AW) + 32'(issue_addr[SLOT_AW-1:0]));

    assign rd_pend_d = issue;
    assign rd_last_d = issue && issue_last;

    wf_bank_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk   (clk_in1),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (wfin_axis_tdata),
        .re    (issue),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        len_d      = len_q;
        reps_d     = reps_q;
        wr_cnt_d   = wr_cnt_q;
        rd_addr_d  = rd_addr_q;
        rep_cnt_d  = rep_cnt_q;
        written_d  = written_q;
        slot_len_d = slot_len_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            STATE_IDLE: begin
                if (accept) begin
                    slot_d = wf_cmd_slot;
                    if (wf_cmd_write) begin
                        if (len_bad) begin
                            err_d = 1'b1;
                        end else begin
                            len_d                  = wf_cmd_len;
                            wr_cnt_d               = '0;
                            written_d[wf_cmd_slot] = 1'b0;
                            state_d                = STATE_WRITE;
                        end
                    end else if (!start_play) begin
                        err_d = 1'b1;
                    end else begin
                        len_d   = play_len;
                        reps_d  = rep_total;
                        state_d = issue_last ? STATE_DRAIN : STATE_PLAY;
                    end
                end
            end
            STATE_WRITE: begin
                if (wfin_axis_tvalid) begin
                    if (wr_last) begin
                        slot_len_d[slot_q] = wr_cnt_q + CW'(1);
                        written_d[slot_q]  = 1'b1;
                        done_d             = 1'b1;
                        state_d            = STATE_IDLE;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CW'(1);
                    end
                end
            end
            STATE_PLAY: begin
                if (issue && issue_last) begin
                    state_d = STATE_DRAIN;
                end
            end
            STATE_DRAIN: begin
                if (pop && wfout_axis_tlast) begin
                    done_d  = 1'b1;
                    state_d = STATE_IDLE;
                end
            end
            default: state_d = STATE_IDLE;
        endcase

        if (issue) begin
            rd_addr_d = issue_wrap ? '0 : issue_addr + CW'(1);
            rep_cnt_d = issue_wrap ? issue_rep + REP_W'(1) : issue_rep;
        end
    end

    // Shift-register FIFO: entry 0 is always the head, so the output only changes on a pop.
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        fill        = fifo_cnt_q;
        if (pop) begin
            fifo_data_d[0] = fifo_data_q[1];
            fifo_last_d[0] = fifo_last_q[1];
            fill           = fill - 2'd1;
        end
        if (rd_pend_q) begin
            fifo_data_d[fill[0]] = ram_rdata;
            fifo_last_d[fill[0]] = rd_last_q;
            fill                 = fill + 2'd1;
        end
        fifo_cnt_d = fill;
    end

    always_ff @(posedge clk_in1 or posedge areset) begin
        if (areset) begin
            state_q     <= STATE_IDLE;
            slot_q      <= '0;
            len_q       <= '0;
            reps_q      <= '0;
            wr_cnt_q    <= '0;
            rd_addr_q   <= '0;
            rep_cnt_q   <= '0;
            written_q   <= '0;
            slot_len_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_last_q   <= 1'b0;
            fifo_data_q <= '0;
            fifo_last_q <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            len_q       <= len_d;
            reps_q      <= reps_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_addr_q   <= rd_addr_d;
            rep_cnt_q   <= rep_cnt_d;
            written_q   <= written_d;
            slot_len_q  <= slot_len_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_pend_q   <= rd_pend_d;
            rd_last_q   <= rd_last_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

endmodule

// File: tb/tb_waveform_bank_stream.sv
// tb/tb_waveform_bank_stream.sv - self-checking bench for waveform_bank_stream
module tb_waveform_bank_stream;

    logic        clk_in1 = 1'b0;
    logic        areset;
    logic        wf_cmd_valid;
    logic        wf_cmd_ready;
    logic        wf_cmd_write;
    logic [1:0]  wf_cmd_slot;
    logic [10:0] wf_cmd_len;
    logic [15:0] wf_cmd_repeat;
    logic [31:0] wfin_axis_tdata;
    logic        wfin_axis_tvalid;
    logic        wfin_axis_tlast;
    logic        wfin_axis_tready;
    logic [31:0] wfout_axis_tdata;
    logic        wfout_axis_tvalid;
    logic        wfout_axis_tlast;
    logic [3:0]  wfout_axis_tkeep;
    logic        wfout_axis_tready;
    logic        wf_done;
    logic        wf_err;
    logic        wf_busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: each slot is simply the list of words that were accepted into it.
    logic [31:0] model_mem [4][$];

    always #5 clk_in1 = ~clk_in1;

    waveform_bank_stream dut (
        .clk_in1           (clk_in1),
        .areset            (areset),
        .wf_cmd_valid      (wf_cmd_valid),
        .wf_cmd_ready      (wf_cmd_ready),
        .wf_cmd_write      (wf_cmd_write),
        .wf_cmd_slot       (wf_cmd_slot),
        .wf_cmd_len        (wf_cmd_len),
        .wf_cmd_repeat     (wf_cmd_repeat),
        .wfin_axis_tdata   (wfin_axis_tdata),
        .wfin_axis_tvalid  (wfin_axis_tvalid),
        .wfin_axis_tlast   (wfin_axis_tlast),
        .wfin_axis_tready  (wfin_axis_tready),
        .wfout_axis_tdata  (wfout_axis_tdata),
        .wfout_axis_tvalid (wfout_axis_tvalid),
        .wfout_axis_tlast  (wfout_axis_tlast),
        .wfout_axis_tkeep  (wfout_axis_tkeep),
        .wfout_axis_tready (wfout_axis_tready),
        .wf_done           (wf_done),
        .wf_err            (wf_err),
        .wf_busy           (wf_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in1);
        #1;
        cyc++;
    endtask

    task automatic issue_cmd(input bit wr, input int slot, input int len, input int rep, output int acc);
        int guard = 0;
        while (!wf_cmd_ready && guard < 200) begin
            tick();
            guard++;
        end
        chk("cmd_ready_wait", wf_cmd_ready, 1);
        wf_cmd_valid  = 1'b1;
        wf_cmd_write  = wr;
        wf_cmd_slot   = 2'(slot);
        wf_cmd_len    = 11'(len);
        wf_cmd_repeat = 16'(rep);
        tick();
        acc = cyc;
        wf_cmd_valid = 1'b0;
    endtask

    task automatic expect_err(input bit wr, input int slot, input int len, input string tag);
        int acc;
        issue_cmd(wr, slot, len, 1, acc);
        chk({tag, "_err_pulse"}, wf_err, 1);
        chk({tag, "_ready_low"}, wf_cmd_ready, 0);
        chk({tag, "_busy_low"}, wf_busy, 0);
        chk({tag, "_no_out"}, wfout_axis_tvalid, 0);
        chk({tag, "_no_in_ready"}, wfin_axis_tready, 0);
        tick();
        chk({tag, "_err_clear"}, wf_err, 0);
        chk({tag, "_ready_back"}, wf_cmd_ready, 1);
        chk({tag, "_no_out2"}, wfout_axis_tvalid, 0);
    endtask

    task automatic store_wf(input int slot, input int len, input int tlast_at, input bit seq, input bit gaps, input string tag);
        logic [31:0] words[$];
        int n_acc, sent, acc;
        bit v, hs;
        n_acc = len;
        if (tlast_at > 0 && tlast_at < n_acc) n_acc = tlast_at;
        for (int i = 0; i < n_acc; i++) words.push_back(seq ? 32'(i) : $urandom);
        issue_cmd(1'b1, slot, len, 0, acc);
        chk({tag, "_busy"}, wf_busy, 1);
        chk({tag, "_in_ready_rise"}, wfin_axis_tready, 1);
        sent = 0;
        for (int c = 0; c < 4 * n_acc + 40 && sent < n_acc; c++) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            wfin_axis_tvalid = v;
            wfin_axis_tdata  = words[sent];
            wfin_axis_tlast  = (sent + 1 == tlast_at);
            hs = v && wfin_axis_tready;
            tick();
            if (hs) sent++;
        end
        wfin_axis_tvalid = 1'b0;
        wfin_axis_tlast  = 1'b0;
        chk({tag, "_beats"}, sent, n_acc);
        chk({tag, "_done_pulse"}, wf_done, 1);
        chk({tag, "_in_ready_fall"}, wfin_axis_tready, 0);
        chk({tag, "_cmd_ready_low"}, wf_cmd_ready, 0);
        tick();
        chk({tag, "_done_clear"}, wf_done, 0);
        chk({tag, "_cmd_ready_back"}, wf_cmd_ready, 1);
        model_mem[slot] = words;
    endtask

    task automatic play_check(input int slot, input int rep, input bit rnd, input string tag);
        logic [31:0] exp_q[$];
        logic [31:0] held_data;
        int n, idx, dones, acc, reps, hs_edge;
        bit first_seen, held, held_last, r;
        reps = (rep == 0) ? 1 : rep;
        for (int k = 0; k < reps; k++)
            for (int j = 0; j < model_mem[slot].size(); j++) exp_q.push_back(model_mem[slot][j]);
        n = exp_q.size();
        issue_cmd(1'b0, slot, 0, rep, acc);
        chk({tag, "_busy"}, wf_busy, 1);
        chk({tag, "_no_valid_yet"}, wfout_axis_tvalid, 0);
        idx = 0; dones = 0; first_seen = 0; held = 0; held_last = 0; held_data = '0; hs_edge = -1;
        for (int c = 0; c < 4 * n + 40 && dones == 0; c++) begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            wfout_axis_tready = r;
            if (held) begin
                chk({tag, "_hold_valid"}, wfout_axis_tvalid, 1);
                chk({tag, "_hold_data"}, wfout_axis_tdata, held_data);
                chk({tag, "_hold_last"}, wfout_axis_tlast, held_last);
            end
            if (wfout_axis_tvalid && !first_seen) begin
                first_seen = 1;
                chk({tag, "_first_valid_latency"}, cyc - acc, 1);
            end
            if (!rnd && first_seen && idx < n) chk({tag, "_no_gap"}, wfout_axis_tvalid, 1);
            if (wfout_axis_tvalid && r) begin
                chk({tag, "_beat_in_range"}, idx < n, 1);
                if (idx < n) chk({tag, "_data"}, wfout_axis_tdata, exp_q[idx]);
                chk({tag, "_tlast"}, wfout_axis_tlast, idx == n - 1);
                idx++;
                hs_edge = cyc + 1;
            end
            held      = wfout_axis_tvalid && !r;
            held_data = wfout_axis_tdata;
            held_last = wfout_axis_tlast;
            tick();
            if (wf_done) begin
                dones++;
                chk({tag, "_done_latency"}, cyc, hs_edge);
            end
        end
        wfout_axis_tready = 1'b0;
        chk({tag, "_beats"}, idx, n);
        chk({tag, "_done_seen"}, dones, 1);
        chk({tag, "_cmd_ready_low"}, wf_cmd_ready, 0);
        tick();
        chk({tag, "_done_clear"}, wf_done, 0);
        chk({tag, "_cmd_ready_back"}, wf_cmd_ready, 1);
        chk({tag, "_idle_no_valid"}, wfout_axis_tvalid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, wf_cmd_ready, 1);
        chk({tag, "_in_ready"}, wfin_axis_tready, 0);
        chk({tag, "_out_valid"}, wfout_axis_tvalid, 0);
        chk({tag, "_out_last"}, wfout_axis_tlast, 0);
        chk({tag, "_done"}, wf_done, 0);
        chk({tag, "_err"}, wf_err, 0);
        chk({tag, "_busy"}, wf_busy, 0);
        chk({tag, "_tkeep"}, wfout_axis_tkeep, 4'hf);
    endtask

    initial begin
        int acc;
        areset            = 1'b1;
        wf_cmd_valid      = 1'b0;
        wf_cmd_write      = 1'b0;
        wf_cmd_slot       = '0;
        wf_cmd_len        = '0;
        wf_cmd_repeat     = '0;
        wfin_axis_tdata   = '0;
        wfin_axis_tvalid  = 1'b0;
        wfin_axis_tlast   = 1'b0;
        wfout_axis_tready = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        areset = 1'b0;
        tick();

        expect_err(1'b0, 0, 0, "play_unwritten");
        expect_err(1'b1, 0, 0, "store_len0");
        expect_err(1'b1, 1, 1025, "store_len_over");

        store_wf(1, 8, 8, 1'b1, 1'b0, "store_s1");
        play_check(1, 1, 1'b0, "play_s1_r1");
        play_check(1, 3, 1'b0, "play_s1_r3");

        store_wf(2, 16, 5, 1'b0, 1'b0, "store_s2_tlast5");
        play_check(2, 0, 1'b0, "play_s2_r0");

        store_wf(0, 1024, 6, 1'b0, 1'b1, "store_s0_full");
        play_check(0, 2, 1'b1, "play_s0_r2_rnd");

        store_wf(3, 8, 0, 1'b0, 1'b1, "store_s3");
        play_check(3, 1, 1'b1, "play_s3_rnd");

        store_wf(0, 1, 0, 1'b0, 1'b0, "store_s0_len1");
        play_check(0, 4, 1'b1, "play_s0_len1_r4");

        // Abort a 16-word store on slot 3 while its third beat is on the bus.
        issue_cmd(1'b1, 3, 16, 0, acc);
        for (int b = 0; b < 2; b++) begin
            wfin_axis_tvalid = 1'b1;
            wfin_axis_tdata  = $urandom;
            tick();
        end
        wfin_axis_tdata = $urandom;
        #3;
        areset = 1'b1;
        #1;
        check_reset_outputs("mid_store_reset");
        tick();
        areset           = 1'b0;
        wfin_axis_tvalid = 1'b0;
        for (int s = 0; s < 4; s++) model_mem[s].delete();
        tick();
        expect_err(1'b0, 3, 0, "play_aborted_slot");
        expect_err(1'b0, 1, 0, "play_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
